// File: rtl/board_io_ctrl.sv
// board_io_ctrl: memory-mapped board I/O peripheral for DE-series boards.
// Synchronises and debounces SW and KEY, latches KEY presses in sticky
// flags, and holds the LED, HEX mode and per-digit HEX registers.
//
// Ports:
//   Clock      in   system clock
//   Reset      in   synchronous active-high reset
//   Addr       in   register address
//   WrData     in   write data
//   W          in   write strobe
//   RdData     out  registered read data (one-cycle latency)
//   KeyPending out  OR of all KEY edge flags
//   SW         in   raw switches (asynchronous)
//   KEY        in   raw pushbuttons (asynchronous, active-low)
//   LEDR       out  LED drive, active-high
//   HEX        out  seven-segment pins, digit d at [7d+6:7d], active-low
//
// Address map: 0 LED, 1 debounced SW, 2 KEY flags (write-1-to-clear),
// 3 HEX mode (1 = raw), 4+d HEX digit d. Other addresses read 0.
module board_io_ctrl #(
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 4,
    parameter int NUM_HEX         = 6,
    parameter int LED_W           = 10,
    parameter int SW_W            = 10,
    parameter int KEY_W           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [ADDR_W-1:0]    Addr,
    input  logic [DATA_W-1:0]    WrData,
    input  logic                 W,
    output logic [DATA_W-1:0]    RdData,
    output logic                 KeyPending,
    input  logic [SW_W-1:0]      SW,
    input  logic [KEY_W-1:0]     KEY,
    output logic [LED_W-1:0]     LEDR,
    output logic [7*NUM_HEX-1:0] HEX
);

    localparam int IN_W  = SW_W + KEY_W;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Idle levels of the combined {KEY, SW} input vector: keys released (1).
    localparam logic [IN_W-1:0]  IN_IDLE  = {{KEY_W{1'b1}}, {SW_W{1'b0}}};
    localparam logic [6:0]       PIN_ZERO = 7'b1000000;

    // Lit-segment pattern (bit 0 = a, 1 = lit) for a hex nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            4'hF:    g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // Active-low pin pattern for one digit register in the given mode.
    function automatic logic [6:0] seg_pins(input logic raw, input logic [6:0] v);
        logic [6:0] lit;
        if (raw) begin
            lit = v;
        end else if (v[4]) begin
            lit = 7'h00;
        end else begin
            lit = hex_glyph(v[3:0]);
        end
        return ~lit;
    endfunction

    logic [IN_W-1:0]    r_meta;
    logic [IN_W-1:0]    r_sync;
    logic [IN_W-1:0]    r_stable;
    logic [CNT_W-1:0]   r_cnt [IN_W];
    logic [KEY_W-1:0]   r_key_prev;
    logic [KEY_W-1:0]   r_flags;
    logic               r_pend;
    logic [LED_W-1:0]   r_led;
    logic [NUM_HEX-1:0] r_mode;
    logic [6:0]         r_digit [NUM_HEX];
    logic [DATA_W-1:0]  r_rd;
    logic [7*NUM_HEX-1:0] r_hex;

    logic [SW_W-1:0]      w_sw_db;
    logic [KEY_W-1:0]     w_key_pressed;
    logic [KEY_W-1:0]     w_set;
    logic [KEY_W-1:0]     w_clr;
    logic [KEY_W-1:0]     w_flags_next;
    logic [DATA_W-1:0]    w_rd;
    logic [DATA_W-1:0]    w_rd_digit;
    logic [7*NUM_HEX-1:0] w_hex;
    logic                 w_unused_wrdata;

    assign w_unused_wrdata = ^WrData;
    assign w_sw_db         = r_stable[SW_W-1:0];
    // Keys are active-low on the board; internally pressed = 1.
    assign w_key_pressed   = ~r_stable[IN_W-1:SW_W];

    // Two-flop synchroniser for all raw inputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_meta <= IN_IDLE;
            r_sync <= IN_IDLE;
        end else begin
            r_meta <= {KEY, SW};
            r_sync <= r_meta;
        end
    end

    // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_stable <= IN_IDLE;
            for (int i = 0; i < IN_W; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (r_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press detection and write-1-to-clear; a new press wins over a clear.
    always_comb begin
        w_set = w_key_pressed & ~r_key_prev;
        if (W && (Addr == ADDR_W'(2))) begin
            w_clr = WrData[KEY_W-1:0];
        end else begin
            w_clr = '0;
        end
        w_flags_next = (r_flags & ~w_clr) | w_set;
    end

    // Edge flag state and pending summary.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_key_prev <= '0;
            r_flags    <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_key_prev <= w_key_pressed;
            r_flags    <= w_flags_next;
            r_pend     <= |w_flags_next;
        end
    end

    // Processor-writable LED, mode and digit registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_led  <= '0;
            r_mode <= '0;
            for (int d = 0; d < NUM_HEX; d++) begin
                r_digit[d] <= 7'h00;
            end
        end else begin
            if (W && (Addr == ADDR_W'(0))) begin
                r_led <= WrData[LED_W-1:0];
            end
            if (W && (Addr == ADDR_W'(3))) begin
                r_mode <= WrData[NUM_HEX-1:0];
            end
            for (int d = 0; d < NUM_HEX; d++) begin
                if (W && (Addr == ADDR_W'(4 + d))) begin
                    r_digit[d] <= WrData[6:0];
                end
            end
        end
    end

    // Read mux over the current (pre-write) register values.
    always_comb begin
        w_rd_digit = '0;
        for (int d = 0; d < NUM_HEX; d++) begin
            w_rd_digit = w_rd_digit |
                ((Addr == ADDR_W'(4 + d)) ? DATA_W'(r_digit[d]) : '0);
        end
        case (Addr)
            ADDR_W'(0): w_rd = DATA_W'(r_led);
            ADDR_W'(1): w_rd = DATA_W'(w_sw_db);
            ADDR_W'(2): w_rd = DATA_W'(r_flags);
            ADDR_W'(3): w_rd = DATA_W'(r_mode);
            default:    w_rd = w_rd_digit;
        endcase
    end

    // Segment pin pattern for every digit.
    always_comb begin
        w_hex = '0;
        for (int d = 0; d < NUM_HEX; d++) begin
            w_hex[7*d +: 7] = seg_pins(r_mode[d], r_digit[d]);
        end
    end

    // Registered read data and HEX pins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rd  <= '0;
            r_hex <= {NUM_HEX{PIN_ZERO}};
        end else begin
            r_rd  <= w_rd;
            r_hex <= w_hex;
        end
    end

    assign RdData     = r_rd;
    assign KeyPending = r_pend;
    assign LEDR       = r_led;
    assign HEX        = r_hex;

endmodule
